// File: rtl/updown_load_counter_pkg.sv
// Shared constants for the up/down loadable counter slice.
package updown_load_counter_pkg;

  localparam int DefaultWidth = 4;

endpackage : updown_load_counter_pkg

// File: rtl/updown_load_counter_tcell.sv
// One-bit toggle cell: synchronous active-low reset, then parallel load, then toggle.
module counter_tcell (
  input  logic clk,
  input  logic res_n,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : counter_tcell

// File: rtl/updown_load_counter.sv
// n-bit synchronous up/down counter with parallel load, built from per-bit T cells
// sharing one clock; the carry/borrow ripple lives only in the toggle logic.
module updown_load_counter
  import updown_load_counter_pkg::*;
#(
  parameter int n = DefaultWidth
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic         count_up,
  input  logic         load,
  input  logic [n-1:0] set,
  output logic [n-1:0] count
);

  logic [n-1:0] toggle;

  for (genvar i = 0; i < n; i++) begin : g_bit
    // A bit flips when every lower bit is 1 (counting up) or all 0 (counting down).
    if (i == 0) begin : g_lsb
      assign toggle[i] = en;
    end else begin : g_upper
      assign toggle[i] = en & (count_up ? (&count[i-1:0]) : ~(|count[i-1:0]));
    end

    counter_tcell u_cell (
      .clk   (clk),
      .res_n (res_n),
      .t     (toggle[i]),
      .ld    (load),
      .d     (set[i]),
      .q     (count[i])
    );
  end

endmodule : updown_load_counter

// File: tb/tb_updown_load_counter.sv
// Directed self-checking bench for updown_load_counter (n=4) using an expected-value queue.
module tb_updown_load_counter;

  localparam int W = 4;

  logic         clk;
  logic         res_n;
  logic         en;
  logic         count_up;
  logic         load;
  logic [W-1:0] set;
  logic [W-1:0] count;

  logic [W-1:0] expQ[$];
  logic [W-1:0] model;
  int           checks;
  int           passes;
  int           fails;

  updown_load_counter #(.n(W)) dut (
    .clk      (clk),
    .res_n    (res_n),
    .en       (en),
    .count_up (count_up),
    .load     (load),
    .set      (set),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs and push the behavioural expectation.
  task automatic applyStimulus(input logic r, input logic e, input logic up,
                               input logic ld, input logic [W-1:0] s);
    res_n    = r;
    en       = e;
    count_up = up;
    load     = ld;
    set      = s;
    if (!r)      model = '0;
    else if (ld) model = s;
    else if (e)  model = up ? model + 1'b1 : model - 1'b1;
    expQ.push_back(model);
  endtask

  // Wait for the edge, then compare the registered count against the oldest expectation.
  task automatic checkOutput(input string tag);
    logic [W-1:0] exp;
    @(posedge clk);
    #1;
    checks++;
    if (expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s scoreboard empty observed=%0d", tag, count);
    end else begin
      exp = expQ.pop_front();
      assert (count === exp) begin
        passes++;
      end else begin
        fails++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, count, exp);
      end
    end
  endtask

  task automatic stepCheck(input logic r, input logic e, input logic up,
                           input logic ld, input logic [W-1:0] s, input string tag);
    applyStimulus(r, e, up, ld, s);
    checkOutput(tag);
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    fails    = 0;
    model    = '0;
    res_n    = 1'b0;
    en       = 1'b0;
    count_up = 1'b1;
    load     = 1'b0;
    set      = '0;
    #2;

    $display("[TB] reset");
    stepCheck(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "reset_en0");
    stepCheck(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, "reset_hold_en1");
    stepCheck(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, "reset_hold_down");

    $display("[TB] count up");
    for (int i = 0; i < 30; i++) stepCheck(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "count_up");

    $display("[TB] count down");
    stepCheck(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "hold_before_down");
    for (int i = 0; i < 32; i++) stepCheck(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "count_down");

    $display("[TB] disabled");
    for (int i = 0; i < 16; i++) stepCheck(1'b1, 1'b0, i[0], 1'b0, 4'(i), "disabled_hold");

    $display("[TB] load then count");
    stepCheck(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, "load_15");
    for (int i = 0; i < 16; i++) stepCheck(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "down_after_load");

    $display("[TB] priority");
    stepCheck(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, "reset_over_load");
    stepCheck(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, "load_over_count");
    stepCheck(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, "count_after_load");
    stepCheck(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, "load_while_disabled");
    stepCheck(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "up_after_load5");
    stepCheck(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "direction_flip");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_updown_load_counter
